// File: rtl/dragon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dragon_pkg
// Purpose  : Shared definitions for the Dragon coherence snoop agent:
//            line-state codes, snoop bus command codes, and a pure
//            next-state function for snooped bus events.
// Contents : ST_NP/ST_SC/ST_M/ST_SM/ST_E state codes
//            CMD_BUSRD/CMD_BUSUPD command codes
//            snoop_res_t     - result of applying a snoop to a line
//            snoop_next()    - Dragon snoop transition function
//            sanitize_state()- maps undefined state codes to NP
// Revision : 1.0 - initial release
// ============================================================================
package dragon_pkg;

  localparam logic [2:0] ST_NP = 3'b000;
  localparam logic [2:0] ST_SC = 3'b001;
  localparam logic [2:0] ST_M  = 3'b010;
  localparam logic [2:0] ST_SM = 3'b011;
  localparam logic [2:0] ST_E  = 3'b100;

  localparam logic [1:0] CMD_BUSRD  = 2'b00;
  localparam logic [1:0] CMD_BUSUPD = 2'b01;

  typedef struct packed {
    logic [2:0] next_state;
    logic       shared;
    logic       flush;
    logic       upd;
    logic       err;
  } snoop_res_t;

  // Effect of a snooped command on a local line. A miss (or a NOP command)
  // leaves the line untouched and produces no bus response.
  function automatic snoop_res_t snoop_next(input logic [1:0] cmd,
                                            input logic       hit,
                                            input logic [2:0] cur);
    snoop_res_t r;
    r.next_state = cur;
    r.shared     = 1'b0;
    r.flush      = 1'b0;
    r.upd        = 1'b0;
    r.err        = 1'b0;
    if (hit) begin
      if (cmd == CMD_BUSRD) begin
        case (cur)
          ST_E, ST_SC: begin
            r.next_state = ST_SC;
            r.shared     = 1'b1;
          end
          ST_M, ST_SM: begin
            // Owner keeps ownership but must supply the dirty data.
            r.next_state = ST_SM;
            r.shared     = 1'b1;
            r.flush      = 1'b1;
          end
          default: ;
        endcase
      end else if (cmd == CMD_BUSUPD) begin
        case (cur)
          ST_SC, ST_SM: begin
            r.next_state = ST_SC;
            r.shared     = 1'b1;
            r.upd        = 1'b1;
          end
          ST_M, ST_E: begin
            // Another cache updating a line we hold exclusively is illegal;
            // still apply the update so the copies stay coherent.
            r.next_state = ST_SC;
            r.shared     = 1'b1;
            r.upd        = 1'b1;
            r.err        = 1'b1;
          end
          default: ;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] sanitize_state(input logic [2:0] s);
    return (s > ST_E) ? ST_NP : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dragon_line_array.sv
`default_nettype none
// ============================================================================
// Module   : dragon_line_array
// Purpose  : Direct-mapped tag/state/data storage for the Dragon snoop agent.
//            State bits reset asynchronously to NP; tags and data do not reset.
// Ports    : clk, rst            - clock, async active-high reset
//            lk_addr_i           - lookup address
//            lk_hit_o/lk_state_o - lookup hit and raw stored state
//            lk_data_o           - lookup stored data
//            qry_addr_i          - debug query address
//            qry_state_o         - query state (NP on tag miss)
//            wr_en_i, wr_addr_i, wr_state_i - tag/state write port
//            wr_data_en_i, wr_data_i        - data write enable and value
// Revision : 1.0 - initial release
// ============================================================================
module dragon_line_array
  import dragon_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int INDEX_BITS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lk_addr_i,
  output logic                  lk_hit_o,
  output logic [2:0]            lk_state_o,
  output logic [DATA_WIDTH-1:0] lk_data_o,
  input  logic [ADDR_WIDTH-1:0] qry_addr_i,
  output logic [2:0]            qry_state_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [2:0]            wr_state_i,
  input  logic                  wr_data_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - 2 - INDEX_BITS;

  logic [2:0]            state_q [LINES];
  logic [TAG_BITS-1:0]   tag_q   [LINES];
  logic [DATA_WIDTH-1:0] data_q  [LINES];

  logic [INDEX_BITS-1:0] lk_idx, qry_idx, wr_idx;
  logic [TAG_BITS-1:0]   lk_tag, qry_tag, wr_tag;
  logic                  w_unused_bits;

  // Byte offset bits never select anything in a word-granular line.
  assign w_unused_bits = ^{lk_addr_i[1:0], qry_addr_i[1:0], wr_addr_i[1:0]};

  assign lk_idx  = lk_addr_i[INDEX_BITS+1:2];
  assign lk_tag  = lk_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign qry_idx = qry_addr_i[INDEX_BITS+1:2];
  assign qry_tag = qry_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign wr_idx  = wr_addr_i[INDEX_BITS+1:2];
  assign wr_tag  = wr_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];

  assign lk_state_o  = state_q[lk_idx];
  assign lk_data_o   = data_q[lk_idx];
  assign lk_hit_o    = (state_q[lk_idx] != ST_NP) && (tag_q[lk_idx] == lk_tag);
  assign qry_state_o = ((state_q[qry_idx] != ST_NP) && (tag_q[qry_idx] == qry_tag))
                       ? state_q[qry_idx] : ST_NP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) state_q[i] <= ST_NP;
    end else if (wr_en_i) begin
      state_q[wr_idx] <= wr_state_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx] <= wr_tag;
      if (wr_data_en_i) data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dragon_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : dragon_snoop_responder
// Purpose  : Snoop-side agent of a Dragon-protocol cache. Looks up snooped
//            BusRd/BusUpd transactions, drives the shared line, flushes
//            dirty data, applies bus updates and moves line state. A local
//            fill port installs or invalidates lines.
// Ports    : clk, rst                        - clock, async active-high reset
//            snp_valid/snp_ready/snp_cmd/snp_addr/snp_data - snoop request
//            shared_out, resp_done, err      - response (valid in RESP)
//            flush_valid/flush_ready/flush_data - dirty-data flush handshake
//            fill_valid/fill_ready/fill_addr/fill_state/fill_data - local fill
//            qry_addr/qry_state              - debug state query
// Revision : 1.0 - initial release
// ============================================================================
module dragon_snoop_responder
  import dragon_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int INDEX_BITS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [1:0]            snp_cmd,
  input  logic [ADDR_WIDTH-1:0] snp_addr,
  input  logic [DATA_WIDTH-1:0] snp_data,
  output logic                  shared_out,
  output logic                  resp_done,
  output logic                  err,
  output logic                  flush_valid,
  input  logic                  flush_ready,
  output logic [DATA_WIDTH-1:0] flush_data,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [2:0]            fill_state,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic [ADDR_WIDTH-1:0] qry_addr,
  output logic [2:0]            qry_state
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOOKUP     = 2'd1,
    S_RESP       = 2'd2,
    S_FLUSH_WAIT = 2'd3
  } fsm_t;

  fsm_t                  state_q, state_d;
  logic [1:0]            cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  shared_q, flush_q, err_q;
  logic [DATA_WIDTH-1:0] flush_data_q;

  logic                  lk_hit;
  logic [2:0]            lk_state;
  logic [DATA_WIDTH-1:0] lk_data;
  snoop_res_t            res;

  logic                  wr_en, wr_data_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_state;
  logic [DATA_WIDTH-1:0] wr_data;

  dragon_line_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .lk_addr_i    (addr_q),
    .lk_hit_o     (lk_hit),
    .lk_state_o   (lk_state),
    .lk_data_o    (lk_data),
    .qry_addr_i   (qry_addr),
    .qry_state_o  (qry_state),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_state_i   (wr_state),
    .wr_data_en_i (wr_data_en),
    .wr_data_i    (wr_data)
  );

  assign res = snoop_next(cmd_q, lk_hit, lk_state);

  // Single write port: LOOKUP owns it for snoop updates, otherwise a fill
  // may use it. Fills are only accepted in IDLE so the two never collide.
  always_comb begin
    wr_en      = 1'b0;
    wr_data_en = 1'b0;
    wr_addr    = fill_addr;
    wr_state   = sanitize_state(fill_state);
    wr_data    = fill_data;
    if (state_q == S_LOOKUP) begin
      wr_en      = lk_hit;
      wr_data_en = res.upd;
      wr_addr    = addr_q;
      wr_state   = res.next_state;
      wr_data    = data_q;
    end else if (fill_valid && fill_ready) begin
      wr_en      = 1'b1;
      wr_data_en = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    snp_ready   = 1'b0;
    fill_ready  = 1'b0;
    resp_done   = 1'b0;
    err         = 1'b0;
    shared_out  = 1'b0;
    flush_valid = 1'b0;
    flush_data  = '0;
    case (state_q)
      S_IDLE: begin
        snp_ready  = 1'b1;
        fill_ready = ~snp_valid;
        if (snp_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_RESP;
      S_RESP: begin
        resp_done   = 1'b1;
        err         = err_q;
        shared_out  = shared_q;
        flush_valid = flush_q;
        flush_data  = flush_q ? flush_data_q : '0;
        state_d     = (flush_q && !flush_ready) ? S_FLUSH_WAIT : S_IDLE;
      end
      S_FLUSH_WAIT: begin
        shared_out  = shared_q;
        flush_valid = 1'b1;
        flush_data  = flush_data_q;
        if (flush_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      shared_q     <= 1'b0;
      flush_q      <= 1'b0;
      err_q        <= 1'b0;
      flush_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && snp_valid) begin
        cmd_q  <= snp_cmd;
        addr_q <= snp_addr;
        data_q <= snp_data;
      end
      if (state_q == S_LOOKUP) begin
        shared_q     <= res.shared;
        flush_q      <= res.flush;
        err_q        <= res.err;
        flush_data_q <= lk_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dragon_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dragon_snoop_responder
// Purpose  : Self-checking bench for dragon_snoop_responder: directed
//            scenarios followed by random fills and snoops, compared with a
//            line-level reference model of the Dragon snoop rules.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dragon_snoop_responder;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int LINES = 16;

  localparam logic [2:0] NP = 3'd0, SC = 3'd1, M = 3'd2, SM = 3'd3, E = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          snp_valid, snp_ready;
  logic [1:0]    snp_cmd;
  logic [AW-1:0] snp_addr;
  logic [DW-1:0] snp_data;
  logic          shared_out, resp_done, err;
  logic          flush_valid, flush_ready;
  logic [DW-1:0] flush_data;
  logic          fill_valid, fill_ready;
  logic [AW-1:0] fill_addr;
  logic [2:0]    fill_state;
  logic [DW-1:0] fill_data;
  logic [AW-1:0] qry_addr;
  logic [2:0]    qry_state;

  always #5 clk = ~clk;

  dragon_snoop_responder #(.ADDR_WIDTH(AW), .INDEX_BITS(4), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd),
    .snp_addr(snp_addr), .snp_data(snp_data),
    .shared_out(shared_out), .resp_done(resp_done), .err(err),
    .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_data(flush_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_state(fill_state), .fill_data(fill_data),
    .qry_addr(qry_addr), .qry_state(qry_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: one entry per line, addressed as the spec describes.
  logic [2:0]  m_state [LINES];
  logic [8:0]  m_tag   [LINES];
  logic [31:0] m_data  [LINES];

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic logic [8:0] tag_of(input logic [AW-1:0] a);
    return a[14:6];
  endfunction

  function automatic logic [2:0] model_lookup(input logic [AW-1:0] a);
    int i = idx_of(a);
    if (m_state[i] != NP && m_tag[i] == tag_of(a)) return m_state[i];
    return NP;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {9'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_qry(input string tag, input logic [AW-1:0] a);
    qry_addr = a;
    #1;
    check(tag, 32'(qry_state), 32'(model_lookup(a)));
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic [2:0] st, input logic [DW-1:0] d);
    int i = idx_of(a);
    fill_valid = 1'b1;
    fill_addr  = a;
    fill_state = st;
    fill_data  = d;
    #1;
    check("fill_ready", 32'(fill_ready), 32'd1);
    step();
    fill_valid = 1'b0;
    m_tag[i]   = tag_of(a);
    m_state[i] = (st > E) ? NP : st;
    m_data[i]  = d;
  endtask

  // Issue one snoop and check the whole response against the model.
  task automatic do_snoop(input logic [1:0] cmd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int stall, input bit with_fill);
    int            i      = idx_of(a);
    logic [2:0]    cur    = model_lookup(a);
    logic          hit    = (cur != NP) && (cmd[1] == 1'b0);
    logic          e_sh   = 1'b0, e_fl = 1'b0, e_err = 1'b0, e_upd = 1'b0;
    logic [2:0]    e_next = cur;
    logic [DW-1:0] e_fd   = m_data[i];
    logic [AW-1:0] faddr  = rand_addr();

    if (hit && cmd == 2'b00) begin
      e_sh   = 1'b1;
      e_fl   = (cur == M) || (cur == SM);
      e_next = e_fl ? SM : SC;
    end
    if (hit && cmd == 2'b01) begin
      e_sh   = 1'b1;
      e_upd  = 1'b1;
      e_err  = (cur == M) || (cur == E);
      e_next = SC;
    end

    check("snp_ready_idle", 32'(snp_ready), 32'd1);
    snp_valid = 1'b1;
    snp_cmd   = cmd;
    snp_addr  = a;
    snp_data  = d;
    if (with_fill) begin
      fill_valid = 1'b1;
      fill_addr  = faddr;
      fill_state = M;
      fill_data  = $urandom;
    end
    #1;
    if (with_fill) check("fill_ready_blocked", 32'(fill_ready), 32'd0);
    step();
    snp_valid  = 1'b0;
    fill_valid = 1'b0;
    check("resp_done_lookup", 32'(resp_done), 32'd0);
    check("snp_ready_busy", 32'(snp_ready), 32'd0);
    step();
    flush_ready = (stall == 0);
    #1;
    check("resp_done", 32'(resp_done), 32'd1);
    check("shared_out", 32'(shared_out), 32'(e_sh));
    check("flush_valid", 32'(flush_valid), 32'(e_fl));
    check("err", 32'(err), 32'(e_err));
    if (e_fl) check("flush_data", flush_data, e_fd);
    if (e_fl) begin
      for (int k = 0; k < stall; k++) begin
        step();
        check("fw_flush_valid", 32'(flush_valid), 32'd1);
        check("fw_flush_data", flush_data, e_fd);
        check("fw_shared", 32'(shared_out), 32'd1);
        check("fw_snp_ready", 32'(snp_ready), 32'd0);
        check("fw_resp_done", 32'(resp_done), 32'd0);
        if (k == stall - 1) flush_ready = 1'b1;
      end
    end
    step();
    flush_ready = 1'b0;
    check("snp_ready_after", 32'(snp_ready), 32'd1);
    check("resp_done_after", 32'(resp_done), 32'd0);
    check("err_after", 32'(err), 32'd0);
    check("flush_valid_after", 32'(flush_valid), 32'd0);
    if (hit) begin
      m_state[i] = e_next;
      if (e_upd) m_data[i] = d;
    end
    check_qry("qry_after_snoop", a);
    if (with_fill) check_qry("qry_fill_not_taken", faddr);
  endtask

  initial begin
    rst = 1'b1;
    snp_valid = 1'b0; snp_cmd = '0; snp_addr = '0; snp_data = '0;
    flush_ready = 1'b0;
    fill_valid = 1'b0; fill_addr = '0; fill_state = '0; fill_data = '0;
    qry_addr = '0;
    for (int i = 0; i < LINES; i++) begin
      m_state[i] = NP; m_tag[i] = '0; m_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_snp_ready", 32'(snp_ready), 32'd1);
    check("rst_resp_done", 32'(resp_done), 32'd0);
    check("rst_flush_valid", 32'(flush_valid), 32'd0);
    check("rst_shared", 32'(shared_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_qry", 32'(qry_state), 32'(NP));
    @(negedge clk);
    rst = 1'b0;
    step();

    // M line flushes on BusRd and becomes SM.
    do_fill(15'h0040, M, 32'h1234_5678);
    do_snoop(2'b00, 15'h0040, 32'h0, 0, 1'b0);
    qry_addr = 15'h0040; #1;
    check("plan_m_to_sm", 32'(qry_state), 32'(SM));

    // E line shared on BusRd; same index with another tag misses.
    do_fill(15'h0080, E, 32'hAAAA_0001);
    do_snoop(2'b00, 15'h0080, 32'h0, 0, 1'b0);
    qry_addr = 15'h0080; #1;
    check("plan_e_to_sc", 32'(qry_state), 32'(SC));
    do_snoop(2'b00, 15'h4080, 32'h0, 0, 1'b0);

    // SM line updated by BusUpd, then read without flush.
    do_fill(15'h0104, SM, 32'h0BAD_F00D);
    do_snoop(2'b01, 15'h0104, 32'hDEAD_BEEF, 0, 1'b0);
    do_snoop(2'b00, 15'h0104, 32'h0, 0, 1'b0);
    do_fill(15'h0104, M, 32'hDEAD_BEEF);
    do_snoop(2'b00, 15'h0104, 32'h0, 0, 1'b0);

    // Flush stalled for three cycles.
    do_fill(15'h00C4, M, 32'hCAFE_0003);
    do_snoop(2'b00, 15'h00C4, 32'h0, 3, 1'b0);

    // BusUpd hitting E is a protocol error; snoop wins over a same-cycle fill.
    do_fill(15'h0148, E, 32'h5555_AAAA);
    do_snoop(2'b01, 15'h0148, 32'h1111_2222, 0, 1'b1);
    qry_addr = 15'h0148; #1;
    check("plan_e_upd_sc", 32'(qry_state), 32'(SC));

    // Randomised traffic.
    for (int it = 0; it < 300; it++) begin
      int            op = $urandom_range(0, 9);
      logic [AW-1:0] a  = rand_addr();
      if (op < 4) do_fill(a, 3'($urandom_range(0, 7)), $urandom);
      else do_snoop(2'($urandom_range(0, 3)), a, $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0));
    end

    // Reset while a flush is stalled.
    do_fill(15'h0040, M, 32'h7777_8888);
    snp_valid = 1'b1; snp_cmd = 2'b00; snp_addr = 15'h0040;
    step();
    snp_valid = 1'b0;
    step();
    check("pre_rst_flush_valid", 32'(flush_valid), 32'd1);
    step();
    check("fw_before_rst", 32'(flush_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_drops_flush", 32'(flush_valid), 32'd0);
    for (int i = 0; i < LINES; i++) m_state[i] = NP;
    for (int i = 0; i < LINES; i++) begin
      qry_addr = {m_tag[i], 4'(i), 2'b00};
      #1;
      check("rst_line_np", 32'(qry_state), 32'(NP));
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    check("snp_ready_after_rst", 32'(snp_ready), 32'd1);
    do_snoop(2'b00, 15'h0040, 32'h0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
